// File: rtl/clock_switch_ctrl_m.sv
// HS/LS clock switch sequencer with hold-off hysteresis and handover watchdog.
// Define CLKCTRL_SWITCH_COUNT_EN to add the switch_cnt_op HS-entry counter.
module clock_switch_ctrl_m #(
  parameter int HOLD_CYCLES = 8,
  parameter int HOLD_W      = 4,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic       hs_ck_ip,
  input  logic       reset_ip,
  input  logic       turbo_en_ip,
  input  logic       cyc_valid_ip,
  input  logic       cyc_ls_ip,
  input  logic       selected_hs_ip,
  input  logic       selected_ls_ip,
  output logic       select_hs_op,
  output logic       rdy_op,
  output logic [1:0] state_op,
  output logic       timeout_op
`ifdef CLKCTRL_SWITCH_COUNT_EN
  ,
  output logic [15:0] switch_cnt_op
`endif
);

  typedef enum logic [1:0] {
    LS_RUN = 2'd0,
    TO_HS  = 2'd1,
    HS_RUN = 2'd2,
    TO_LS  = 2'd3
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYCLES);
  localparam logic [TO_W-1:0]   TO_LIM  = TO_W'(TIMEOUT);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   wdog;
  logic              sync1;
  logic              sel_ls_s;
  logic              ls_req;
  logic              wd_hit;
  logic              ls_done;

  assign ls_req  = cyc_valid_ip & cyc_ls_ip;
  assign wd_hit  = (wdog == TO_LIM);
  assign ls_done = sel_ls_s & ~selected_hs_ip;

  always_ff @(posedge hs_ck_ip) begin
    if (reset_ip) begin
      state        <= LS_RUN;
      select_hs_op <= 1'b0;
      timeout_op   <= 1'b0;
      hold_cnt     <= HOLD_LD;
      wdog         <= '0;
      sync1        <= 1'b0;
      sel_ls_s     <= 1'b0;
    end else begin
      sync1    <= selected_ls_ip;
      sel_ls_s <= sync1;
      unique case (state)
        LS_RUN: begin
          wdog <= '0;
          if (ls_req)
            hold_cnt <= HOLD_LD;
          else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
          // timeout_op latches us here until reset
          if (hold_cnt == '0 && turbo_en_ip &&
              !timeout_op && !ls_req) begin
            state        <= TO_HS;
            select_hs_op <= 1'b1;
          end
        end
        TO_HS: begin
          if (selected_hs_ip) begin
            state <= HS_RUN;
            wdog  <= '0;
          end else if (wd_hit) begin
            state        <= TO_LS;
            select_hs_op <= 1'b0;
            timeout_op   <= 1'b1;
            wdog         <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        HS_RUN: begin
          wdog <= '0;
          if (ls_req || !turbo_en_ip) begin
            state        <= TO_LS;
            select_hs_op <= 1'b0;
          end
        end
        TO_LS: begin
          if (ls_done || wd_hit) begin
            if (!ls_done)
              timeout_op <= 1'b1;
            state    <= LS_RUN;
            hold_cnt <= HOLD_LD;
            wdog     <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef CLKCTRL_SWITCH_COUNT_EN
  always_ff @(posedge hs_ck_ip) begin
    if (reset_ip)
      switch_cnt_op <= '0;
    else if (state == TO_HS && selected_hs_ip &&
             switch_cnt_op != 16'hFFFF)
      switch_cnt_op <= switch_cnt_op + 1'b1;
  end
`endif

  // LS cycles are stalled combinationally in the cycle they appear
  assign rdy_op   = (state == LS_RUN) |
                    ((state == HS_RUN) & ~ls_req);
  assign state_op = state;

endmodule

// File: tb/tb_clock_switch_ctrl_m.sv
// Self-checking bench for clock_switch_ctrl_m.
// Rule-level model compared every cycle plus literal spot checks.
module tb_clock_switch_ctrl_m;

  localparam int HOLD = 8;
  localparam int TMO  = 255;

  logic       clk;
  logic       reset_ip;
  logic       turbo;
  logic       cv;
  logic       cl;
  logic       shs;
  logic       sls;
  logic       select_hs_op;
  logic       rdy_op;
  logic [1:0] state_op;
  logic       timeout_op;
`ifdef CLKCTRL_SWITCH_COUNT_EN
  logic [15:0] switch_cnt_op;
`endif

  int total = 0;
  int bad   = 0;

  clock_switch_ctrl_m dut (
    .hs_ck_ip      (clk),
    .reset_ip      (reset_ip),
    .turbo_en_ip   (turbo),
    .cyc_valid_ip  (cv),
    .cyc_ls_ip     (cl),
    .selected_hs_ip(shs),
    .selected_ls_ip(sls),
    .select_hs_op  (select_hs_op),
    .rdy_op        (rdy_op),
    .state_op      (state_op),
    .timeout_op    (timeout_op)
`ifdef CLKCTRL_SWITCH_COUNT_EN
    ,
    .switch_cnt_op (switch_cnt_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  // model: mode 0=LS 1=going HS 2=HS 3=going LS
  int m_mode;
  int quiet;
  int age;
  bit m_to;
  bit h0, h1;
  int m_cnt;
  bit armed = 0;

  always @(posedge clk) begin
    bit req, sync_ok;
    req = cv & cl;
    sync_ok = h1 & !shs;
    if (reset_ip) begin
      m_mode = 0; quiet = 0; age = 0;
      m_to = 0; h0 = 0; h1 = 0; m_cnt = 0;
      armed = 1;
    end else begin
      if (m_mode == 0) begin
        if (quiet >= HOLD && turbo && !m_to && !req) begin
          m_mode = 1; age = 0;
        end else begin
          quiet = req ? 0 : quiet + 1;
        end
      end else if (m_mode == 1) begin
        if (shs) begin
          m_mode = 2;
          if (m_cnt < 65535) m_cnt++;
        end else if (age == TMO) begin
          m_mode = 3; m_to = 1; age = 0;
        end else age++;
      end else if (m_mode == 2) begin
        if (req || !turbo) begin
          m_mode = 3; age = 0;
        end
      end else begin
        if (sync_ok || age == TMO) begin
          if (!sync_ok) m_to = 1;
          m_mode = 0; quiet = 0;
        end else age++;
      end
      h1 = h0;
      h0 = sls;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_state", state_op, m_mode);
      chk("m_sel", select_hs_op,
          (m_mode == 1 || m_mode == 2) ? 1 : 0);
      chk("m_rdy", rdy_op,
          (m_mode == 0 || (m_mode == 2 && !(cv && cl)))
          ? 1 : 0);
      chk("m_to", timeout_op, m_to);
`ifdef CLKCTRL_SWITCH_COUNT_EN
      chk("m_cnt", switch_cnt_op, m_cnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int max,
                            output int n);
    n = 0;
    while (state_op != s && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic round_trip();
    int n;
    wait_state(1, 50, n);
    chk("rt_to_hs", state_op, 1);
    shs = 1; tick();
    chk("rt_hs", state_op, 2);
    cv = 1; cl = 1; tick();
    cv = 0; cl = 0; shs = 0; sls = 1;
    wait_state(0, 20, n);
    sls = 0;
    chk("rt_ls", state_op, 0);
  endtask

  initial begin
    int n;
    reset_ip = 1; turbo = 1; cv = 0; cl = 0;
    shs = 0; sls = 0;
    tick(); tick();
    reset_ip = 0;
    chk("rst_state", state_op, 0);
    chk("rst_sel", select_hs_op, 0);
    chk("rst_rdy", rdy_op, 1);
    chk("rst_to", timeout_op, 0);

    wait_state(1, 50, n);
    chk("ls_dwell", n, 9);
    chk("to_hs_sel", select_hs_op, 1);
    chk("to_hs_rdy", rdy_op, 0);
    tick(); tick();
    shs = 1; tick();
    chk("hs_run", state_op, 2);
    chk("hs_rdy", rdy_op, 1);

    cv = 1; cl = 1; #1;
    chk("ls_stall", rdy_op, 0);
    tick();
    chk("to_ls", state_op, 3);
    cv = 0; cl = 0;
    sls = 1; shs = 0;
    wait_state(0, 20, n);
    chk("ls_sync", n, 3);
    chk("ls_rdy", rdy_op, 1);
    sls = 0;

    for (int k = 0; k < 6; k++) begin
      cv = 1; cl = 1; tick();
      cv = 0; cl = 0;
      repeat (4) tick();
      chk("hyst_stay", state_op, 0);
    end
    cv = 1; cl = 1; tick();
    cv = 0; cl = 0;
    wait_state(1, 50, n);
    chk("hyst_exit", n, 9);

    wait_state(3, 400, n);
    chk("wdog_trip", n, 256);
    chk("wdog_flag", timeout_op, 1);
    sls = 1;
    wait_state(0, 20, n);
    chk("fb_ls", n, 3);
    sls = 0;
    repeat (40) tick();
    chk("fb_hold", state_op, 0);
    chk("fb_flag", timeout_op, 1);

    reset_ip = 1; tick(); reset_ip = 0;
    chk("rst2_to", timeout_op, 0);
    wait_state(1, 50, n);
    chk("dwell2", n, 9);
    turbo = 0; shs = 1; tick();
    chk("tdrop_hs", state_op, 2);
    tick();
    chk("tdrop_ls", state_op, 3);
    shs = 0; sls = 1;
    wait_state(0, 20, n);
    sls = 0;
    repeat (30) tick();
    chk("toff_ls", state_op, 0);

    turbo = 1;
    wait_state(1, 50, n);
    chk("pre_rst", state_op, 1);
    reset_ip = 1; tick(); reset_ip = 0;
    chk("mid_state", state_op, 0);
    chk("mid_sel", select_hs_op, 0);
    chk("mid_rdy", rdy_op, 1);
    chk("mid_to", timeout_op, 0);
`ifdef CLKCTRL_SWITCH_COUNT_EN
    chk("cnt_rst", switch_cnt_op, 0);
`endif
    repeat (3) round_trip();
`ifdef CLKCTRL_SWITCH_COUNT_EN
    chk("cnt_3", switch_cnt_op, 3);
`endif
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
